// File: rtl/ckpt_rename_table.sv
`default_nettype none
// ============================================================================
// Module   : ckpt_rename_table
// Purpose  : Speculative register rename map with per-physical-register ready
//            bits, intra-group RAW/WAW bypass, same-cycle writeback bypass,
//            an in-order queue of branch snapshots for single-cycle
//            mispredict recovery, and a committed map for full flush.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            rename_*/dest_*/src*  - rename group in, renamed sources out
//            preg_i                - free-list registers for each slot's dest
//            ckpt_req_i/ckpt_id_o  - snapshot request and allocated id
//            ppdst_o               - previous mapping of each slot's dest
//            wb_*                  - writeback ports (set ready)
//            commit_*              - in-order commit into the committed map
//            ckpt_free_i           - release oldest snapshot
//            recover_*             - restore map from a snapshot
//            flush_i               - restore map from the committed map
// Revision : 1.0 - initial release
// ============================================================================
module ckpt_rename_table #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int RENAME_WIDTH = 2,
  parameter int WB_WIDTH     = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int CKPT_NUM     = 4,
  localparam int PW = $clog2(PHY_REG_NUM),
  localparam int AW = $clog2(ARCH_REG_NUM),
  localparam int CW = $clog2(CKPT_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rename_valid_i,
  output logic                            rename_ready_o,
  input  logic [RENAME_WIDTH-1:0]         dest_valid_i,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] src0_i,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] src1_i,
  input  logic [RENAME_WIDTH-1:0][AW-1:0] dest_i,
  input  logic [RENAME_WIDTH-1:0][PW-1:0] preg_i,
  input  logic [RENAME_WIDTH-1:0]         ckpt_req_i,
  output logic [CW-1:0]                   ckpt_id_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0] psrc0_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0] psrc1_o,
  output logic [RENAME_WIDTH-1:0]         psrc0_ready_o,
  output logic [RENAME_WIDTH-1:0]         psrc1_ready_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0] ppdst_o,
  input  logic [WB_WIDTH-1:0]             wb_i,
  input  logic [WB_WIDTH-1:0][PW-1:0]     wb_pdest_i,
  input  logic [COMMIT_WIDTH-1:0]         commit_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0] commit_areg_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0] commit_preg_i,
  input  logic                            ckpt_free_i,
  input  logic                            recover_i,
  input  logic [CW-1:0]                   recover_id_i,
  input  logic                            flush_i
);

  localparam logic [CW:0] CKPT_FULL = (CW+1)'(CKPT_NUM);

  logic [PW-1:0]          spec_map   [ARCH_REG_NUM];
  logic [PW-1:0]          commit_map [ARCH_REG_NUM];
  logic [PW-1:0]          snap       [CKPT_NUM][ARCH_REG_NUM];
  logic [PHY_REG_NUM-1:0] ready;
  logic [CW-1:0]          head;
  logic [CW-1:0]          tail;
  logic [CW:0]            count;

  logic [RENAME_WIDTH-1:0] dest_live;
  logic                    ckpt_any;
  logic                    accept;
  logic                    ckpt_alloc;
  logic [CW-1:0]           recover_off;
  logic [PW-1:0]           next_map    [ARCH_REG_NUM];
  logic [PW-1:0]           snap_data   [ARCH_REG_NUM];
  logic [PW-1:0]           commit_next [ARCH_REG_NUM];

  // r0 is hardwired to p0, so a dest of 0 never renames or bypasses.
  always_comb begin
    dest_live = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      dest_live[i] = dest_valid_i[i] && (dest_i[i] != '0);
    end
  end

  assign ckpt_any       = |ckpt_req_i;
  assign rename_ready_o = !(flush_i || recover_i) && ((count < CKPT_FULL) || !ckpt_any);
  assign accept         = rename_valid_i && rename_ready_o;
  assign ckpt_alloc     = accept && ckpt_any;
  assign ckpt_id_o      = tail;
  assign recover_off    = recover_id_i - head;

  // Source/ppdst lookup. Base value comes from the map plus writeback
  // bypass; ascending j makes the youngest older matching slot win.
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      psrc0_o[i]       = spec_map[src0_i[i]];
      psrc1_o[i]       = spec_map[src1_i[i]];
      ppdst_o[i]       = spec_map[dest_i[i]];
      psrc0_ready_o[i] = ready[psrc0_o[i]];
      psrc1_ready_o[i] = ready[psrc1_o[i]];
      for (int k = 0; k < WB_WIDTH; k++) begin
        if (wb_i[k] && (wb_pdest_i[k] == psrc0_o[i])) psrc0_ready_o[i] = 1'b1;
        if (wb_i[k] && (wb_pdest_i[k] == psrc1_o[i])) psrc1_ready_o[i] = 1'b1;
      end
      for (int j = 0; j < i; j++) begin
        if (dest_live[j] && (dest_i[j] == src0_i[i])) begin
          psrc0_o[i]       = preg_i[j];
          psrc0_ready_o[i] = 1'b0;
        end
        if (dest_live[j] && (dest_i[j] == src1_i[i])) begin
          psrc1_o[i]       = preg_i[j];
          psrc1_ready_o[i] = 1'b0;
        end
        if (dest_live[j] && (dest_i[j] == dest_i[i])) begin
          ppdst_o[i] = preg_i[j];
        end
      end
    end
  end

  // Apply slots in order; the snapshot captures the map right after the
  // requesting slot, so the branch's own dest is included but younger
  // slots are not.
  always_comb begin
    next_map  = spec_map;
    snap_data = spec_map;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (dest_live[i]) next_map[dest_i[i]] = preg_i[i];
      if (ckpt_req_i[i]) snap_data = next_map;
    end
    commit_next = commit_map;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (commit_i[c] && (commit_areg_i[c] != '0)) begin
        commit_next[commit_areg_i[c]] = commit_preg_i[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        spec_map[i]   <= PW'(i);
        commit_map[i] <= PW'(i);
      end
      ready <= '1;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      commit_map <= commit_next;
      if (flush_i) begin
        // Same-cycle commits are folded in via commit_next.
        spec_map <= commit_next;
        ready    <= '1;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        // Writeback is applied after the rename clear so it wins on a
        // (never legal) collision.
        for (int i = 0; i < RENAME_WIDTH; i++) begin
          if (accept && dest_live[i]) ready[preg_i[i]] <= 1'b0;
        end
        for (int k = 0; k < WB_WIDTH; k++) begin
          if (wb_i[k]) ready[wb_pdest_i[k]] <= 1'b1;
        end
        head <= head + CW'(ckpt_free_i);
        if (recover_i) begin
          // The recovered snapshot stays live: it is the new youngest.
          spec_map <= snap[recover_id_i];
          tail     <= recover_id_i + 1'b1;
          count    <= {1'b0, recover_off} + (CW+1)'(1) - (CW+1)'(ckpt_free_i);
        end else begin
          if (accept) spec_map <= next_map;
          if (ckpt_alloc) begin
            snap[tail] <= snap_data;
            tail       <= tail + 1'b1;
          end
          count <= count + (CW+1)'(ckpt_alloc) - (CW+1)'(ckpt_free_i);
        end
      end
    end
  end

  a_one_ckpt_per_group: assert property (@(posedge clk) disable iff (!rst_n)
    rename_valid_i |-> $onehot0(ckpt_req_i));
  a_free_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    (ckpt_free_i && !flush_i) |-> (count != '0));
  a_recover_live: assert property (@(posedge clk) disable iff (!rst_n)
    (recover_i && !flush_i) |-> ({1'b0, recover_off} < count));

endmodule
`default_nettype wire
